// File: rtl/joybus_pkg.sv
// rtl/joybus_pkg.sv - shared types, constants and level-pattern helpers for the Joybus line path
//
// Contents:
//   DEFAULT_LEVEL_WIDTH, DEFAULT_CRC_POLY : default timing and CRC polynomial
//   tx_state_t                            : transmitter frame state
//   encode_bit()                          : line level for one quarter of a data bit
//   stop_level()                          : line level for one quarter of the stop bit

package joybus_pkg;

    localparam int         DEFAULT_LEVEL_WIDTH = 2;
    localparam logic [7:0] DEFAULT_CRC_POLY    = 8'h85;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BITS,
        ST_CRC,
        ST_STOP
    } tx_state_t;

    // A data bit is four levels: always low first, always high last, and the
    // two middle levels carry the bit value (0 -> L,L,L,H ; 1 -> L,H,H,H).
    function automatic logic encode_bit(input logic bit_val, input logic [1:0] level_idx);
        logic lvl;
        case (level_idx)
            2'd0:    lvl = 1'b0;
            2'd3:    lvl = 1'b1;
            default: lvl = bit_val;
        endcase
        return lvl;
    endfunction

    // Stop bit: the first low_levels quarters are low, the rest released high.
    function automatic logic stop_level(input logic [1:0] level_idx, input int low_levels);
        int idx;
        idx = int'(level_idx);
        return (idx >= low_levels);
    endfunction

endpackage

// File: rtl/joybus_crc8.sv
// rtl/joybus_crc8.sv - bit-serial CRC-8, MSB-first, no augmentation
//
// Ports:
//   sample_clk : clock
//   reset      : asynchronous active-high reset, clears the remainder
//   clear      : synchronous clear to 0x00 (takes priority over enable)
//   enable     : shift bit_in into the remainder this cycle
//   bit_in     : next message bit
//   rem_out    : current remainder

module joybus_crc8
    import joybus_pkg::*;
#(
    parameter logic [7:0] POLY = DEFAULT_CRC_POLY
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] rem_out
);

    logic fb;

    assign fb = rem_out[7] ^ bit_in;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            rem_out <= 8'h00;
        end else if (clear) begin
            rem_out <= 8'h00;
        end else if (enable) begin
            rem_out <= {rem_out[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
    end

endmodule

// File: rtl/joybus_tx.sv
// rtl/joybus_tx.sv - Joybus single-wire transmitter with streamed payload, optional CRC-8 and stop bit
//
// Ports:
//   sample_clk : sole clock
//   reset      : asynchronous active-high reset
//   start      : frame request, sampled only while idle
//   byte_count : payload length in bytes, captured with start
//   append_crc : send CRC-8 byte after the payload, captured with start
//   tx_data    : payload byte, MSB sent first
//   tx_valid   : tx_data valid
//   tx_ready   : byte accepted when tx_valid & tx_ready
//   busy       : frame in progress
//   done       : one-cycle end-of-frame pulse
//   underrun   : with done, frame was cut short for lack of data
//   data_tx    : registered line level, 1 = released

module joybus_tx
    import joybus_pkg::*;
#(
    parameter int         LEVEL_WIDTH     = DEFAULT_LEVEL_WIDTH,
    parameter int         MAX_BYTES       = 33,
    parameter int         STOP_LOW_LEVELS = 2,
    parameter logic [7:0] CRC_POLY        = DEFAULT_CRC_POLY,
    localparam int        BCW             = $clog2(MAX_BYTES + 1)
) (
    input  logic           sample_clk,
    input  logic           reset,
    input  logic           start,
    input  logic [BCW-1:0] byte_count,
    input  logic           append_crc,
    input  logic [7:0]     tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic           busy,
    output logic           done,
    output logic           underrun,
    output logic           data_tx
);

    localparam int             LCW      = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
    localparam logic [LCW-1:0] LVL_LAST = LCW'(LEVEL_WIDTH - 1);

    tx_state_t      state, state_n;
    logic [LCW-1:0] lvl_cnt, lvl_cnt_n;       // cycles within the current level
    logic [1:0]     lvl_idx, lvl_idx_n;       // quarter within the current bit
    logic [2:0]     bit_idx, bit_idx_n;       // bits left in cur_byte after this one
    logic [7:0]     cur_byte, cur_byte_n;     // shift register, bit 7 is on the line
    logic [7:0]     hold_data, hold_data_n;
    logic           hold_full, hold_full_n;
    logic [BCW-1:0] fetch_left, fetch_left_n; // payload bytes not yet handshaken
    logic           crc_on, crc_on_n;
    logic           und_flag, und_flag_n;
    logic           data_tx_n, done_n, underrun_n;

    logic           last_cycle;
    logic           take;
    logic           crc_clear;
    logic           crc_en;
    logic [7:0]     crc_rem;

    assign busy       = (state != ST_IDLE);
    assign tx_ready   = ((state == ST_LOAD) || (state == ST_BITS)) && !hold_full && (fetch_left != '0);
    assign take       = tx_valid & tx_ready;
    assign last_cycle = (lvl_cnt == LVL_LAST) && (lvl_idx == 2'd3);

    // Each payload bit enters the CRC on its first cycle, so the remainder is
    // complete well before the last payload bit ends and the CRC byte loads.
    assign crc_clear = (state == ST_IDLE) && start;
    assign crc_en    = (state == ST_BITS) && (lvl_idx == 2'd0) && (lvl_cnt == '0);

    joybus_crc8 #(
        .POLY (CRC_POLY)
    ) u_crc (
        .sample_clk (sample_clk),
        .reset      (reset),
        .clear      (crc_clear),
        .enable     (crc_en),
        .bit_in     (cur_byte[7]),
        .rem_out    (crc_rem)
    );

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lvl_cnt    <= '0;
            lvl_idx    <= 2'd0;
            bit_idx    <= 3'd7;
            cur_byte   <= 8'h00;
            hold_data  <= 8'h00;
            hold_full  <= 1'b0;
            fetch_left <= '0;
            crc_on     <= 1'b0;
            und_flag   <= 1'b0;
            data_tx    <= 1'b1;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            lvl_cnt    <= lvl_cnt_n;
            lvl_idx    <= lvl_idx_n;
            bit_idx    <= bit_idx_n;
            cur_byte   <= cur_byte_n;
            hold_data  <= hold_data_n;
            hold_full  <= hold_full_n;
            fetch_left <= fetch_left_n;
            crc_on     <= crc_on_n;
            und_flag   <= und_flag_n;
            data_tx    <= data_tx_n;
            done       <= done_n;
            underrun   <= underrun_n;
        end
    end

    always_comb begin
        state_n      = state;
        lvl_cnt_n    = lvl_cnt;
        lvl_idx_n    = lvl_idx;
        bit_idx_n    = bit_idx;
        cur_byte_n   = cur_byte;
        hold_data_n  = hold_data;
        hold_full_n  = hold_full;
        fetch_left_n = fetch_left;
        crc_on_n     = crc_on;
        und_flag_n   = und_flag;
        done_n       = 1'b0;
        underrun_n   = 1'b0;
        data_tx_n    = 1'b1;

        // Level timing runs freely in every state that drives the line.
        if ((state == ST_BITS) || (state == ST_CRC) || (state == ST_STOP)) begin
            if (lvl_cnt != LVL_LAST) begin
                lvl_cnt_n = lvl_cnt + 1'b1;
            end else begin
                lvl_cnt_n = '0;
                lvl_idx_n = lvl_idx + 2'd1;
            end
        end

        if (take) begin
            fetch_left_n = fetch_left - 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    fetch_left_n = byte_count;
                    crc_on_n     = append_crc;
                    und_flag_n   = 1'b0;
                    hold_full_n  = 1'b0;
                    lvl_cnt_n    = '0;
                    lvl_idx_n    = 2'd0;
                    bit_idx_n    = 3'd7;
                    // CRC of an empty payload is the init value.
                    cur_byte_n   = 8'h00;
                    if (byte_count != '0) begin
                        state_n = ST_LOAD;
                    end else if (append_crc) begin
                        state_n = ST_CRC;
                    end else begin
                        state_n = ST_STOP;
                    end
                end
            end

            ST_LOAD: begin
                // First byte bypasses the holding register straight onto the line.
                if (take) begin
                    state_n    = ST_BITS;
                    cur_byte_n = tx_data;
                    lvl_cnt_n  = '0;
                    lvl_idx_n  = 2'd0;
                    bit_idx_n  = 3'd7;
                end
            end

            ST_BITS: begin
                if (take) begin
                    hold_data_n = tx_data;
                    hold_full_n = 1'b1;
                end
                if (last_cycle) begin
                    if (bit_idx != 3'd0) begin
                        bit_idx_n  = bit_idx - 1'b1;
                        cur_byte_n = {cur_byte[6:0], 1'b0};
                    end else begin
                        bit_idx_n = 3'd7;
                        if (hold_full) begin
                            cur_byte_n  = hold_data;
                            hold_full_n = 1'b0;
                        end else if (take) begin
                            // A byte arriving on the boundary cycle goes straight
                            // to the shifter rather than being lost.
                            cur_byte_n  = tx_data;
                            hold_full_n = 1'b0;
                        end else if (fetch_left != '0) begin
                            state_n    = ST_STOP;
                            und_flag_n = 1'b1;
                        end else if (crc_on) begin
                            state_n    = ST_CRC;
                            cur_byte_n = crc_rem;
                        end else begin
                            state_n = ST_STOP;
                        end
                    end
                end
            end

            ST_CRC: begin
                if (last_cycle) begin
                    if (bit_idx != 3'd0) begin
                        bit_idx_n  = bit_idx - 1'b1;
                        cur_byte_n = {cur_byte[6:0], 1'b0};
                    end else begin
                        bit_idx_n = 3'd7;
                        state_n   = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (last_cycle) begin
                    state_n    = ST_IDLE;
                    done_n     = 1'b1;
                    underrun_n = und_flag;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // The line register is loaded from the next position so data_tx always
        // shows the level belonging to the state it is in.
        case (state_n)
            ST_BITS, ST_CRC: data_tx_n = encode_bit(cur_byte_n[7], lvl_idx_n);
            ST_STOP:         data_tx_n = stop_level(lvl_idx_n, STOP_LOW_LEVELS);
            default:         data_tx_n = 1'b1;
        endcase
    end

endmodule

// File: doc/joybus_tx.md
# joybus_tx

Parametrised Joybus line transmitter, successor to the fixed-response N64 controller Tx path. It streams an arbitrary-length payload from a byte handshake onto the single-wire bus, optionally appends a serial CRC-8, and closes each frame with a configurable stop bit. Response content is decided upstream; this block owns only line timing, encoding, CRC and framing. It sits between the controller response logic and the open-drain pad driver.

## Interface
- LEVEL_WIDTH, 2: sample_clk cycles per level (quarter-bit); must be ≥1.
- MAX_BYTES, 33: largest payload length in bytes.
- STOP_LOW_LEVELS, 2: low levels in stop bit (1 = console stop, 2 = controller stop); the remaining 4−STOP_LOW_LEVELS levels are high.
- CRC_POLY, 8'h85: CRC-8 polynomial.
- sample_clk  in  1  sole clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- byte_count  in  $clog2(MAX_BYTES+1)  payload bytes; captured with start.
- append_crc  in  1  send CRC byte after payload; captured with start.
- tx_data  in  8  payload byte, MSB sent first.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block accepts tx_data this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.
- underrun  out  1  qualifies done: frame aborted for lack of data.
- data_tx  out  1  line level; 1 = released/high.

## Operation
- Reset values: data_tx=1, tx_ready=0, busy=0, done=0, underrun=0; holding register empty, CRC=0, state IDLE.
- Encoding: logic 0 = L,L,L,H; logic 1 = L,H,H,H; each level lasts LEVEL_WIDTH cycles; bit time = 4·LEVEL_WIDTH.
- States: IDLE → LOAD (start, byte_count>0) or STOP (start, byte_count=0, append_crc=0) or CRC (start, byte_count=0, append_crc=1); LOAD → BITS on first byte accepted; BITS → BITS on next byte, → CRC after last payload byte if append_crc, → STOP otherwise or on underrun; CRC → STOP after 8 bits; STOP → IDLE.
- Byte handshake: transfer when tx_valid & tx_ready. One holding register; tx_ready=1 while the register is empty and payload bytes remain un-fetched. In LOAD the line stays high indefinitely until the first byte arrives.
- Underrun: at the last cycle of a byte's final bit, if bytes remain and the register is empty → go to STOP, skip CRC; done and underrun pulse together.
- CRC: init 0x00 at start; per payload bit b, MSB-first: fb=crc[7]^b; crc={crc[6:0],0} ^ (fb?CRC_POLY:0). No augmentation. CRC byte sent MSB-first and not itself fed into the CRC.
- start while busy: ignored. tx_valid outside tx_ready: ignored.

## Timing
- data_tx is registered. First low level begins the cycle after the first byte handshake (or after start when no payload is needed).
- Bits are back-to-back; no gap between bytes or before the CRC/stop bit.
- Frame length from first low = (8·byte_count + 8·append_crc + 1)·4·LEVEL_WIDTH cycles.
- done, busy=0, data_tx=1 all occur the cycle after the last stop-bit cycle; a new start is accepted in that same cycle.
- Reset mid-frame: data_tx returns high asynchronously; no done pulse; any partial byte is discarded.

## Structure
- Package joybus_pkg: state enum, encode_bit() level-pattern function, default CRC_POLY and LEVEL_WIDTH constants, stop-pattern helper.
- Sub-module joybus_crc8: serial CRC with clear, enable, bit-in and rem-out ports, parametrised by polynomial. This module is reused by the Rx path.
- Single level counter, bit counter and byte counter, all in the sample_clk domain. No derived or gated clocks.

## Test plan
- LEVEL_WIDTH=2, bytes {05,00,02}, append_crc=0 → 25 bit times (200 cycles); first bit L6/H2; byte0 bit5 L2/H6; stop L4/H4; single done, underrun=0.
- Payload {01}, append_crc=1 → line carries 0x01 then 0x85, then stop; 17 bit times total.
- byte_count=2, only the first byte offered → stop follows 8 data bits; done=underrun=1; 9 bit times total; no CRC byte.
- byte_count=0, append_crc=0, STOP_LOW_LEVELS=1, LEVEL_WIDTH=1 → data_tx reads 0,1,1,1 starting the cycle after start; done on the next cycle.
- Reset asserted during bit 10 → data_tx=1 and busy=0 immediately with no done; the next frame {FF} is bit-exact.
- start pulsed mid-frame → ignored; frame length unchanged; back-to-back start in the done cycle is accepted.
